// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and IF/ID pipeline register with branch redirect, stall and HLT.
// Optional FETCH_COUNT_EN adds a wrapping count of instructions loaded into IF/ID.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        taken,
  input  logic [15:0] PC_branch,
  input  logic [15:0] instr_in,
  output logic [15:0] PC_curr,
  output logic [15:0] PC_next,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_PC_next,
  output logic        IF_ID_valid,
  output logic        halted,
  output logic [1:0]  fetch_state
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;

  logic [1:0]  state;
  logic [15:0] pc_q;
  logic [15:0] branch_target;
  logic        is_hlt;
  logic        load_normal;
  logic        branch_lsb_unused;

  // Instructions are halfword aligned, so the target's bit 0 never reaches the PC.
  assign branch_target     = {PC_branch[15:1], 1'b0};
  assign branch_lsb_unused = PC_branch[0];

  assign is_hlt      = (instr_in[15:12] == HLT_OPCODE);
  assign load_normal = !stall && !taken && (state != ST_HALT);

  assign PC_curr     = pc_q;
  assign PC_next     = pc_q + 16'd2;
  assign halted      = (state == ST_HALT);
  assign fetch_state = state;

  // Priority: stall > taken (flush) > halted hold > normal fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= {RESET_PC[15:1], 1'b0};
      IF_ID_instr   <= NOP_INSTR;
      IF_ID_PC_next <= 16'h0000;
      IF_ID_valid   <= 1'b0;
      state         <= ST_RUN;
    end else if (stall) begin
      pc_q          <= pc_q;
    end else if (taken) begin
      pc_q          <= branch_target;
      IF_ID_instr   <= NOP_INSTR;
      IF_ID_PC_next <= PC_next;
      IF_ID_valid   <= 1'b0;
      state         <= ST_RUN;
    end else if (state == ST_RUN) begin
      IF_ID_instr   <= instr_in;
      IF_ID_PC_next <= PC_next;
      IF_ID_valid   <= 1'b1;
      if (is_hlt) begin
        state <= ST_HALT;
      end else begin
        pc_q  <= PC_next;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 16'h0000;
    end else if (load_normal) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`else
  logic load_normal_unused;
  assign load_normal_unused = load_normal;
`endif

endmodule
